// File: rtl/seq_div8.sv
// seq_div8: 8-bit unsigned restoring divider iterating through a cla8bit add/subtract unit.
// Latency: done pulses 8 clocks after the accepting edge (same edge for a zero divisor).
// Backpressure: start is ignored while busy; there is no queuing and no restart mid-divide.

// cla8bit: 8-bit carry-lookahead adder/subtractor (control=1 subtracts b from a).
// Latency: purely combinational.
// Backpressure: none.
module cla8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       control,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout,
  output logic       o
);

  logic [7:0] b_eff;
  logic [7:0] g;
  logic [7:0] p;
  logic       c0;
  logic [4:0] c_lo;
  logic [4:0] c_hi;
  logic [8:0] c;

  // Carries for one 4-bit lookahead group; bit 0 is the group carry-in, bit 4 its carry-out.
  function automatic logic [4:0] cla4_carries(input logic [3:0] gg,
                                              input logic [3:0] pp,
                                              input logic       ci);
    logic [4:0] cc;
    cc[0] = ci;
    cc[1] = gg[0] | (pp[0] & ci);
    cc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & ci);
    cc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
          | (pp[2] & pp[1] & pp[0] & ci);
    cc[4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
          | (pp[3] & pp[2] & pp[1] & gg[0])
          | (pp[3] & pp[2] & pp[1] & pp[0] & ci);
    return cc;
  endfunction

  // Subtract mode inverts b and injects the +1 of two's complement through the carry-in,
  // so control=1 with cin=0 yields a-b and cout=1 exactly when a>=b.
  always_comb begin
    b_eff = b ^ {8{control}};
    c0    = cin ^ control;
    g     = a & b_eff;
    p     = a ^ b_eff;
    c_lo  = cla4_carries(g[3:0], p[3:0], c0);
    c_hi  = cla4_carries(g[7:4], p[7:4], c_lo[4]);
    c     = {c_hi, c_lo[3:0]};
    s     = p ^ c[7:0];
    cout  = c[8];
    o     = c[8] ^ c[7];
  end

endmodule

module seq_div8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  // The datapath is tied to a single cla8bit instance, so any other width is a build error.
  if (WIDTH != 8) begin : g_width_check
    $error("seq_div8: WIDTH must be 8 to match the cla8bit datapath");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] d_q, d_d;             // latched divisor
  logic [WIDTH-1:0] q_q, q_d;             // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] r_q, r_d;             // partial remainder
  logic [2:0]       cnt_q, cnt_d;         // iterations completed
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] x;                    // low byte of the shifted remainder
  logic [WIDTH-1:0] cla_s;
  logic             cla_cout;
  logic             unused_cla_o;
  logic             qb;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;

  // Shifted remainder is {r_q[7], x}; only the low byte goes through the subtractor.
  assign x = {r_q[WIDTH-2:0], q_q[WIDTH-1]};

  cla8bit u_cla (
    .a       (x),
    .b       (d_q),
    .control (1'b1),
    .cin     (1'b0),
    .s       (cla_s),
    .cout    (cla_cout),
    .o       (unused_cla_o)
  );

  // Quotient bit and post-iteration registers. When the shifted remainder is 9 bits wide
  // (r_q[7] set) it is always >= the divisor, and the subtractor's low byte is still exact.
  always_comb begin
    qb     = r_q[WIDTH-1] | cla_cout;
    r_next = qb ? cla_s : x;
    q_next = {q_q[WIDTH-2:0], qb};
  end

  // Next-state logic: accept in IDLE, one restoring step per clock in RUN.
  always_comb begin
    state_d     = state_q;
    d_d         = d_q;
    q_d         = q_q;
    r_d         = r_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    done_d      = 1'b0;
    dbz_d       = dbz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            // Zero divisor completes immediately without iterating.
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            done_d      = 1'b1;
          end else begin
            d_d     = divisor;
            q_d     = dividend;
            r_d     = '0;
            cnt_d   = '0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        r_d   = r_next;
        q_d   = q_next;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          // Final iteration: publish this step's results directly.
          quotient_d  = q_next;
          remainder_d = r_next;
          dbz_d       = 1'b0;
          done_d      = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset that overrides any divide in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      d_q         <= '0;
      q_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      d_q         <= d_d;
      q_q         <= q_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign busy        = (state_q == RUN);
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div8.sv
// tb_seq_div8: directed and swept checks of seq_div8 results, latency and handshake.
// Latency: expects done 8 clocks after acceptance, or at the accepting edge for divisor 0.
// Backpressure: verifies start is ignored while busy and accepted during the done cycle.
module tb_seq_div8;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_div8 #(.WIDTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Issue one divide (called #1 after a rising edge) and wait for done, bounded.
  // inj_at >= 0 pulses a second start (50/5) for one cycle at that RUN cycle.
  task automatic do_div(input logic [7:0] a, input logic [7:0] b, input int inj_at,
                        output logic [7:0] qo, output logic [7:0] ro, output logic dz,
                        output int lat, output int bcnt);
    int n;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n     = 0;
    bcnt  = 0;
    while (!done && n < 20) begin
      if (busy) bcnt++;
      if (n == inj_at) begin
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd5;
      end else if (n == inj_at + 1) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    qo    = quotient;
    ro    = remainder;
    dz    = div_by_zero;
    lat   = n;
  endtask

  task automatic run(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input int inj_at, input logic [7:0] eq, input logic [7:0] er,
                     input logic edz);
    logic [7:0] qo, ro;
    logic       dz;
    int         lat, bcnt;
    do_div(a, b, inj_at, qo, ro, dz, lat, bcnt);
    chk({tag, " quotient"}, qo, eq);
    chk({tag, " remainder"}, ro, er);
    chk({tag, " div_by_zero"}, dz, edz);
    chk({tag, " latency"}, lat, (b == 8'd0) ? 0 : 8);
    chk({tag, " busy_cycles"}, bcnt, (b == 8'd0) ? 0 : 8);
  endtask

  // done must fall after exactly one cycle.
  task automatic pulse_end(input string tag);
    @(posedge clk); #1;
    chk({tag, " done_one_cycle"}, done, 1'b0);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst quotient", quotient, 8'd0);
    chk("rst remainder", remainder, 8'd0);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst div_by_zero", div_by_zero, 1'b0);

    run("200/7", 8'd200, 8'd7, -1, 8'd28, 8'd4, 1'b0);
    pulse_end("200/7");
    run("250/130", 8'd250, 8'd130, -1, 8'd1, 8'd120, 1'b0);
    pulse_end("250/130");
    run("255/1", 8'd255, 8'd1, -1, 8'd255, 8'd0, 1'b0);
    pulse_end("255/1");
    run("13/200", 8'd13, 8'd200, -1, 8'd0, 8'd13, 1'b0);
    pulse_end("13/200");
    run("0/5", 8'd0, 8'd5, -1, 8'd0, 8'd0, 1'b0);
    pulse_end("0/5");

    run("77/0", 8'd77, 8'd0, -1, 8'hFF, 8'd77, 1'b1);
    pulse_end("77/0");
    chk("77/0 hold quotient", quotient, 8'hFF);
    chk("77/0 hold remainder", remainder, 8'd77);
    chk("77/0 hold div_by_zero", div_by_zero, 1'b1);

    // Second start during RUN is ignored; the next start lands in the done cycle.
    run("100/9 ignore", 8'd100, 8'd9, 3, 8'd11, 8'd1, 1'b0);
    run("50/5 b2b", 8'd50, 8'd5, -1, 8'd10, 8'd0, 1'b0);
    pulse_end("50/5 b2b");
    chk("after b2b busy", busy, 1'b0);

    // Reset in the middle of a divide.
    dividend = 8'd200;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst busy before", busy, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst busy", busy, 1'b0);
    chk("midrst done", done, 1'b0);
    chk("midrst quotient", quotient, 8'd0);
    chk("midrst remainder", remainder, 8'd0);
    run("9/3", 8'd9, 8'd3, -1, 8'd3, 8'd0, 1'b0);
    pulse_end("9/3");

    // Boundary grid plus pseudo-random pairs against an arithmetic reference.
    begin
      logic [7:0] av [11] = '{8'd0, 8'd1, 8'd2, 8'd7, 8'd100, 8'd127,
                              8'd128, 8'd129, 8'd200, 8'd254, 8'd255};
      logic [7:0] bv [10] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd7, 8'd127,
                              8'd128, 8'd129, 8'd200, 8'd255};
      for (int i = 0; i < 11; i++) begin
        for (int j = 0; j < 10; j++) begin
          logic [7:0] eq, er;
          eq = (bv[j] == 8'd0) ? 8'hFF : 8'(int'(av[i]) / int'(bv[j]));
          er = (bv[j] == 8'd0) ? av[i] : 8'(int'(av[i]) % int'(bv[j]));
          run($sformatf("grid %0d/%0d", av[i], bv[j]), av[i], bv[j], -1,
              eq, er, bv[j] == 8'd0);
          pulse_end($sformatf("grid %0d/%0d", av[i], bv[j]));
        end
      end
      for (int k = 0; k < 200; k++) begin
        logic [7:0] a, b, eq, er;
        a  = 8'($urandom_range(0, 255));
        b  = 8'($urandom_range(0, 255));
        eq = (b == 8'd0) ? 8'hFF : 8'(int'(a) / int'(b));
        er = (b == 8'd0) ? a : 8'(int'(a) % int'(b));
        run($sformatf("rnd %0d/%0d", a, b), a, b, -1, eq, er, b == 8'd0);
        pulse_end($sformatf("rnd %0d/%0d", a, b));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
